// File: rtl/dict_image_loader.sv
// Boot-time loader: reads a dictionary image header plus entries from memory, streams each
// entry into its dictionary, then hands the memory port to the fetch controller.
module dict_image_loader #(
    parameter int unsigned FIELD1_KEY_WIDTH = 3,
    parameter int unsigned FIELD2_KEY_WIDTH = 5,
    parameter int unsigned FIELD3_KEY_WIDTH = 8,
    parameter int unsigned FIELD1_VAL_WIDTH = 7,
    parameter int unsigned FIELD2_VAL_WIDTH = 10,
    parameter int unsigned FIELD3_VAL_WIDTH = 15,
    parameter logic [31:0] IMAGE_BASE       = 32'h0001_0000
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    output logic                        load_done,
    output logic                        busy,
    output logic                        cfg_error,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [31:0]                 mem_req_addr,
    input  logic [31:0]                 mem_req_rdata,
    input  logic                        ctrl_mem_req_valid,
    output logic                        ctrl_mem_req_ready,
    input  logic [31:0]                 ctrl_mem_req_addr,
    output logic [31:0]                 ctrl_mem_req_rdata,
    output logic                        dict1_write_enable,
    output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
    output logic                        dict2_write_enable,
    output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
    output logic                        dict3_write_enable,
    output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
);
    localparam int unsigned Cap1 = 1 << FIELD1_KEY_WIDTH;
    localparam int unsigned Cap2 = 1 << FIELD2_KEY_WIDTH;
    localparam int unsigned Cap3 = 1 << FIELD3_KEY_WIDTH;

    typedef enum logic [2:0] {StIdle, StHdr, StD1, StD2, StD3, StDone} state_e;

    state_e                      state_q, state_d;
    logic                        valid_q, valid_d;
    logic [31:0]                 addr_q, addr_d;
    logic [3:0]                  cnt1_q, cnt1_d;
    logic [5:0]                  cnt2_q, cnt2_d;
    logic [8:0]                  cnt3_q, cnt3_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;
    logic                        err_q, err_d;
    logic                        en1_q, en1_d, en2_q, en2_d, en3_q, en3_d;
    logic [FIELD1_VAL_WIDTH-1:0] val1_q, val1_d;
    logic [FIELD2_VAL_WIDTH-1:0] val2_q, val2_d;
    logic [FIELD3_VAL_WIDTH-1:0] val3_q, val3_d;

    logic       fire;
    logic [3:0] hdr1;
    logic [5:0] hdr2;
    logic [8:0] hdr3;
    logic       over1, over2, over3;

    assign fire  = valid_q & mem_req_ready;
    assign hdr1  = mem_req_rdata[3:0];
    assign hdr2  = mem_req_rdata[9:4];
    assign hdr3  = mem_req_rdata[18:10];
    assign over1 = 32'(hdr1) > Cap1;
    assign over2 = 32'(hdr2) > Cap2;
    assign over3 = 32'(hdr3) > Cap3;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            cnt3_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            en3_q   <= 1'b0;
            val1_q  <= '0;
            val2_q  <= '0;
            val3_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            cnt3_q  <= cnt3_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            en3_q   <= en3_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
            val3_q  <= val3_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        cnt3_d  = cnt3_q;
        done_d  = done_q;
        busy_d  = busy_q;
        err_d   = err_q;
        en1_d   = 1'b0;
        en2_d   = 1'b0;
        en3_d   = 1'b0;
        val1_d  = val1_q;
        val2_d  = val2_q;
        val3_d  = val3_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHdr;
                    valid_d = 1'b1;
                    addr_d  = IMAGE_BASE;
                    busy_d  = 1'b1;
                end
            end
            StHdr, StD1, StD2, StD3: begin
                if (fire) begin
                    valid_d = 1'b0;
                    addr_d  = addr_q + 32'd4;
                    case (state_q)
                        StHdr: begin
                            // Clamped counts only: an oversized field shifts later fields' data.
                            cnt1_d = over1 ? 4'(Cap1) : hdr1;
                            cnt2_d = over2 ? 6'(Cap2) : hdr2;
                            cnt3_d = over3 ? 9'(Cap3) : hdr3;
                            err_d  = err_q | over1 | over2 | over3;
                        end
                        StD1: begin
                            en1_d  = 1'b1;
                            val1_d = mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                            cnt1_d = cnt1_q - 4'd1;
                        end
                        StD2: begin
                            en2_d  = 1'b1;
                            val2_d = mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                            cnt2_d = cnt2_q - 6'd1;
                        end
                        StD3: begin
                            en3_d  = 1'b1;
                            val3_d = mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                            cnt3_d = cnt3_q - 9'd1;
                        end
                        default: ;
                    endcase
                end else if (!valid_q) begin
                    // Gap cycle: pick the next non-empty field, so empty fields cost nothing.
                    valid_d = 1'b1;
                    if (cnt1_q != '0) begin
                        state_d = StD1;
                    end else if (cnt2_q != '0) begin
                        state_d = StD2;
                    end else if (cnt3_q != '0) begin
                        state_d = StD3;
                    end else begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            StDone: ;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if (state_q == StDone) begin
            mem_req_valid      = ctrl_mem_req_valid;
            mem_req_addr       = ctrl_mem_req_addr;
            ctrl_mem_req_ready = mem_req_ready;
            ctrl_mem_req_rdata = mem_req_rdata;
        end else begin
            mem_req_valid      = valid_q;
            mem_req_addr       = addr_q;
            ctrl_mem_req_ready = 1'b0;
            ctrl_mem_req_rdata = '0;
        end
    end

    assign load_done          = done_q;
    assign busy               = busy_q;
    assign cfg_error          = err_q;
    assign dict1_write_enable = en1_q;
    assign dict2_write_enable = en2_q;
    assign dict3_write_enable = en3_q;
    assign dict1_write_val    = val1_q;
    assign dict2_write_val    = val2_q;
    assign dict3_write_val    = val3_q;

endmodule

// File: tb/tb_dict_image_loader.sv
// Directed bench for dict_image_loader: drives a small memory image cycle by cycle and
// checks strobes, addresses, latency, clamping, stalls, pass-through and async reset.
module tb_dict_image_loader;
    localparam logic [31:0] Base = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        load_done, busy, cfg_error;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_rdata;
    logic        ctrl_mem_req_valid, ctrl_mem_req_ready;
    logic [31:0] ctrl_mem_req_addr, ctrl_mem_req_rdata;
    logic        dict1_write_enable, dict2_write_enable, dict3_write_enable;
    logic [6:0]  dict1_write_val;
    logic [9:0]  dict2_write_val;
    logic [14:0] dict3_write_val;

    always #5 clk = ~clk;

    dict_image_loader dut (
        .clk                (clk),
        .resetn             (resetn),
        .start              (start),
        .load_done          (load_done),
        .busy               (busy),
        .cfg_error          (cfg_error),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_addr       (mem_req_addr),
        .mem_req_rdata      (mem_req_rdata),
        .ctrl_mem_req_valid (ctrl_mem_req_valid),
        .ctrl_mem_req_ready (ctrl_mem_req_ready),
        .ctrl_mem_req_addr  (ctrl_mem_req_addr),
        .ctrl_mem_req_rdata (ctrl_mem_req_rdata),
        .dict1_write_enable (dict1_write_enable),
        .dict1_write_val    (dict1_write_val),
        .dict2_write_enable (dict2_write_enable),
        .dict2_write_val    (dict2_write_val),
        .dict3_write_enable (dict3_write_enable),
        .dict3_write_val    (dict3_write_val)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] mem      [0:15];
    logic [31:0] addr_log [0:15];
    logic [31:0] log1     [0:15];
    logic [31:0] log2     [0:15];
    logic [31:0] log3     [0:15];
    int n_wr1, n_wr2, n_wr3, n_words, cyc;
    int multi_en, valid_drop, addr_unstable, gap_err, ctrl_leak, busy_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        start         = 1'b0;
        mem_req_ready = 1'b0;
        mem_req_rdata = 32'h0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Pulses start, then acts as memory: ready after lat (+stall_cyc on word stall_word) valid
    // cycles. Stops at load_done or at max_cyc edges counted from the start-sampling edge.
    task automatic run_load(input int stall_word, input int stall_cyc, input int lat,
                            input int max_cyc, input bit poke);
        int          wait_cnt;
        int          need;
        int          idx;
        bit          gap;
        logic [31:0] prev_addr;
        wait_cnt = 0; gap = 1'b0; prev_addr = '0;
        n_wr1 = 0; n_wr2 = 0; n_wr3 = 0; n_words = 0;
        multi_en = 0; valid_drop = 0; addr_unstable = 0; gap_err = 0; ctrl_leak = 0;
        busy_bad = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (load_done !== 1'b1 && cyc < max_cyc) begin
            if (dict1_write_enable === 1'b1 && n_wr1 < 16) begin
                log1[n_wr1] = 32'(dict1_write_val); n_wr1++;
            end
            if (dict2_write_enable === 1'b1 && n_wr2 < 16) begin
                log2[n_wr2] = 32'(dict2_write_val); n_wr2++;
            end
            if (dict3_write_enable === 1'b1 && n_wr3 < 16) begin
                log3[n_wr3] = 32'(dict3_write_val); n_wr3++;
            end
            if (32'(dict1_write_enable) + 32'(dict2_write_enable) + 32'(dict3_write_enable) > 1)
                multi_en++;
            if (ctrl_mem_req_ready !== 1'b0 || ctrl_mem_req_rdata !== 32'h0) ctrl_leak++;
            if (busy !== 1'b1) busy_bad++;
            if (gap && mem_req_valid !== 1'b0) gap_err++;
            if (wait_cnt > 0 && mem_req_valid !== 1'b1) valid_drop++;
            if (wait_cnt > 0 && mem_req_addr !== prev_addr) addr_unstable++;
            gap           = 1'b0;
            mem_req_ready = 1'b0;
            mem_req_rdata = 32'hA5A5_A5A5;
            if (mem_req_valid === 1'b1) begin
                need = lat + ((n_words == stall_word) ? stall_cyc : 0);
                if (wait_cnt >= need) begin
                    idx           = int'((mem_req_addr - Base) >> 2) & 15;
                    mem_req_ready = 1'b1;
                    mem_req_rdata = mem[idx];
                    if (n_words < 16) addr_log[n_words] = mem_req_addr;
                    n_words++;
                    wait_cnt = 0;
                    gap      = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
            prev_addr = mem_req_addr;
            start     = (poke && cyc == 4) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        mem_req_ready = 1'b0;
        start         = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; mem_req_ready = 1'b0; mem_req_rdata = '0;
        ctrl_mem_req_valid = 1'b0; ctrl_mem_req_addr = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Basic load: n1=2, n2=1, n3=1, ready one cycle after valid.
        do_reset();
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_error", 32'(cfg_error), 32'd0);
        chk("rst_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_addr", mem_req_addr, 32'h0);
        chk("rst_ctrl_ready", 32'(ctrl_mem_req_ready), 32'd0);
        mem[0] = 32'h0000_0412; mem[1] = 32'hFFFF_FFB3; mem[2] = 32'h0000_0013;
        mem[3] = 32'hFFFF_FC00; mem[4] = 32'h1234_0123;
        run_load(-1, 0, 1, 200, 1'b0);
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_cycles", 32'(cyc), 32'd16);
        chk("t1_n_wr1", 32'(n_wr1), 32'd2);
        chk("t1_d1_v0", log1[0], 32'h33);
        chk("t1_d1_v1", log1[1], 32'h13);
        chk("t1_n_wr2", 32'(n_wr2), 32'd1);
        chk("t1_d2_v0", log2[0], 32'h000);
        chk("t1_n_wr3", 32'(n_wr3), 32'd1);
        chk("t1_d3_v0", log3[0], 32'h0123);
        chk("t1_words", 32'(n_words), 32'd5);
        for (int i = 0; i < 5; i++) chk("t1_addr", addr_log[i], Base + 32'(4 * i));
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_cfg_error", 32'(cfg_error), 32'd0);
        chk("t1_multi_en", 32'(multi_en), 32'd0);
        chk("t1_gap", 32'(gap_err), 32'd0);
        chk("t1_busy_during", 32'(busy_bad), 32'd0);

        // Empty image: header only, load_done three edges after start.
        do_reset();
        mem[0] = 32'h0;
        run_load(-1, 0, 0, 200, 1'b0);
        chk("t2_cycles", 32'(cyc), 32'd3);
        chk("t2_words", 32'(n_words), 32'd1);
        chk("t2_strobes", 32'(n_wr1 + n_wr2 + n_wr3), 32'd0);
        chk("t2_done", 32'(load_done), 32'd1);

        // Oversized n1=9 clamps to 8 and sets cfg_error.
        do_reset();
        mem[0] = 32'h0000_0009;
        for (int i = 1; i < 16; i++) mem[i] = 32'h0000_0F00 + 32'h10 + 32'(i - 1);
        run_load(-1, 0, 0, 200, 1'b0);
        chk("t3_cycles", 32'(cyc), 32'd19);
        chk("t3_n_wr1", 32'(n_wr1), 32'd8);
        chk("t3_words", 32'(n_words), 32'd9);
        chk("t3_d1_first", log1[0], 32'h10);
        chk("t3_d1_last", log1[7], 32'h17);
        chk("t3_last_addr", addr_log[8], Base + 32'd32);
        chk("t3_cfg_error", 32'(cfg_error), 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_cfg_sticky", 32'(cfg_error), 32'd1);

        // Stall of 5 cycles on entry 2, ctrl requests and stray start pulses during load.
        do_reset();
        chk("t4_cfg_cleared", 32'(cfg_error), 32'd0);
        ctrl_mem_req_valid = 1'b1;
        ctrl_mem_req_addr  = 32'h0000_0040;
        mem[0] = 32'h3; mem[1] = 32'h01; mem[2] = 32'h02; mem[3] = 32'h03;
        run_load(2, 5, 0, 200, 1'b1);
        chk("t4_cycles", 32'(cyc), 32'd14);
        chk("t4_n_wr1", 32'(n_wr1), 32'd3);
        chk("t4_d1_v1", log1[1], 32'h02);
        chk("t4_words", 32'(n_words), 32'd4);
        chk("t4_valid_drop", 32'(valid_drop), 32'd0);
        chk("t4_addr_stable", 32'(addr_unstable), 32'd0);
        chk("t4_gap", 32'(gap_err), 32'd0);
        chk("t4_ctrl_stalled", 32'(ctrl_leak), 32'd0);
        chk("t4_pt_valid", 32'(mem_req_valid), 32'd1);
        chk("t4_pt_addr", mem_req_addr, 32'h0000_0040);
        chk("t4_pt_ready_lo", 32'(ctrl_mem_req_ready), 32'd0);
        mem_req_ready = 1'b1;
        mem_req_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t4_pt_ready", 32'(ctrl_mem_req_ready), 32'd1);
        chk("t4_pt_rdata", ctrl_mem_req_rdata, 32'hDEAD_BEEF);
        ctrl_mem_req_valid = 1'b0;
        #1;
        chk("t4_pt_valid_lo", 32'(mem_req_valid), 32'd0);
        mem_req_ready = 1'b0;
        @(negedge clk);

        // Reset during D2 clears everything asynchronously; a new start reloads from the header.
        do_reset();
        mem[0] = 32'h0000_0031; mem[1] = 32'h0000_0055; mem[2] = 32'h0000_03AB;
        mem[3] = 32'h0000_02CD; mem[4] = 32'h0000_01EF;
        run_load(-1, 0, 0, 7, 1'b0);
        chk("t6_mid_n_wr2", 32'(n_wr2), 32'd1);
        chk("t6_mid_d2_v0", log2[0], 32'h3AB);
        chk("t6_mid_valid", 32'(mem_req_valid), 32'd1);
        chk("t6_mid_addr", mem_req_addr, Base + 32'd12);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(mem_req_valid), 32'd0);
        chk("t6_rst_addr", mem_req_addr, 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(load_done), 32'd0);
        chk("t6_rst_en", {29'd0, dict1_write_enable, dict2_write_enable, dict3_write_enable},
            32'd0);
        chk("t6_rst_val1", 32'(dict1_write_val), 32'd0);
        chk("t6_rst_val2", 32'(dict2_write_val), 32'd0);
        #1 resetn = 1'b1;
        @(negedge clk);
        run_load(-1, 0, 0, 200, 1'b0);
        chk("t6_cycles", 32'(cyc), 32'd11);
        chk("t6_words", 32'(n_words), 32'd5);
        chk("t6_first_addr", addr_log[0], Base);
        chk("t6_n_wr1", 32'(n_wr1), 32'd1);
        chk("t6_d1_v0", log1[0], 32'h55);
        chk("t6_n_wr2", 32'(n_wr2), 32'd3);
        chk("t6_d2_v2", log2[2], 32'h1EF);
        chk("t6_done", 32'(load_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dict_image_loader.md
Name: dict_image_loader

Overview:
Boot-time sequencer that fills the three compression dictionaries (field1/field2/field3) from a dictionary image held in instruction memory.
It owns the single memory port while loading, streaming one value per dictionary write strobe.
Once loading finishes it passes the instruction-fetch controller's refill traffic straight through to memory.
It sits between the fetch controller, its dictionaries and the memory.

Parameters:
FIELD1_KEY_WIDTH, 3, dict1 key width; capacity C1 = 2^3 = 8
FIELD2_KEY_WIDTH, 5, dict2 key width; capacity C2 = 32
FIELD3_KEY_WIDTH, 8, dict3 key width; capacity C3 = 256
FIELD1_VAL_WIDTH, 7, dict1 value width
FIELD2_VAL_WIDTH, 10, dict2 value width
FIELD3_VAL_WIDTH, 15, dict3 value width
IMAGE_BASE, 32'h0001_0000, byte address of the image header word

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins load (honoured in IDLE only)
load_done  out  1  high once load completes; stays high until reset
busy  out  1  high from start accepted until load_done
cfg_error  out  1  sticky; a header count exceeded capacity
mem_req_valid  out  1  memory read request
mem_req_ready  in  1  memory data valid, one-cycle pulse
mem_req_addr  out  32  memory word address (byte-addressed, [1:0]=0)
mem_req_rdata  in  32  memory read data
ctrl_mem_req_valid  in  1  fetch-controller request
ctrl_mem_req_ready  out  1  to fetch controller
ctrl_mem_req_addr  in  32  fetch-controller address
ctrl_mem_req_rdata  out  32  to fetch controller
dict1_write_enable  out  1  dict1 append strobe
dict1_write_val  out  FIELD1_VAL_WIDTH  dict1 value
dict2_write_enable  out  1  dict2 append strobe
dict2_write_val  out  FIELD2_VAL_WIDTH  dict2 value
dict3_write_enable  out  1  dict3 append strobe
dict3_write_val  out  FIELD3_VAL_WIDTH  dict3 value

Behaviour:
- Reset (async, resetn=0): state IDLE.
  - All registered outputs are 0: mem_req_valid, mem_req_addr, all dictN_write_enable, all dictN_write_val, load_done, busy, cfg_error, internal counters.
  - Reset mid-load aborts the load immediately.
- Image format:
  - Header word at IMAGE_BASE: n1=[3:0], n2=[9:4], n3=[18:10]; other bits ignored.
  - Entry words follow at consecutive word addresses in this order: n1 dict1 values, then n2 dict2 values, then n3 dict3 values.
  - Each value is taken from the word's low VAL_WIDTH bits.
- Count clamp:
  - If nK > CK, the effective count is CK and cfg_error is set to 1.
  - The address pointer still advances over only the effective entries, so later-field data is read from the shifted position. This is deliberate and documented; software must not rely on it.
- States: IDLE -> HDR -> D1 -> D2 -> D3 -> DONE.
  - IDLE: waits for start. start outside IDLE is ignored.
  - In D1/D2/D3, a field with effective count 0 is skipped in zero cycles of memory traffic.
- Read handshake, per word:
  - Set mem_req_valid=1 with mem_req_addr registered.
  - Hold both until a cycle where mem_req_valid & mem_req_ready.
  - In that cycle capture rdata. Next cycle: mem_req_valid=0 (a mandatory one-cycle gap) and addr += 4.
  - Minimum 2 cycles per word.
- Dictionary writes:
  - The cycle after an entry's ready, the matching dictN_write_enable=1 for exactly one cycle with dictN_write_val = captured value.
  - Never more than one enable high at once.
  - dictN_write_val holds its last value when its enable is low.
- Sequencing: after the last entry of the last non-empty field, enter DONE; load_done=1 and busy=0 in the same cycle.
- DONE (pass-through), combinational:
  - mem_req_valid = ctrl_mem_req_valid
  - mem_req_addr = ctrl_mem_req_addr
  - ctrl_mem_req_ready = mem_req_ready
  - ctrl_mem_req_rdata = mem_req_rdata
- Outside DONE, the fetch controller is stalled: ctrl_mem_req_ready=0 and ctrl_mem_req_rdata=0, and ctrl requests are ignored.
- mem_req_ready while mem_req_valid=0 is ignored.
- Total load latency, start pulse to load_done, with memory ready on the first valid cycle: 2*(1+n1+n2+n3)+1 cycles.

Test Plan:
- Reset then start; header 32'h0000_0412 (n1=2, n2=1, n3=1), entries 7'h33, 7'h13, 10'h000, 15'h0123, memory ready 1 cycle after valid -> dict1 strobes 7'h33 then 7'h13, then dict2 10'h000, then dict3 15'h0123. Addresses 0x10000..0x10010 step 4. load_done=1, cfg_error=0.
- Header 0 -> only the header is read; load_done asserted 3 cycles after start; no write strobes.
- Header n1=9 (bits [3:0]=4'h9) -> exactly 8 dict1 strobes; cfg_error=1 sticky through DONE.
- Memory stalls ready for 5 cycles on entry 2 -> mem_req_valid and mem_req_addr held stable for all 5 cycles; no duplicate strobe.
- ctrl_mem_req_valid=1 during load -> ctrl_mem_req_ready stays 0. After DONE, ctrl addr 32'h0000_0040 appears on mem_req_addr the same cycle, and rdata 32'hDEADBEEF is returned with ready.
- resetn pulled low during D2 -> all outputs 0 asynchronously. A new start after reset restarts from the header; start pulses during a load are ignored.
